transposicao_matriz_seq: RTL

//  Sequential, parametrised matrix transpose engine for the operations datapath.
//  - Accepts a packed square matrix (2x2 up to DIM_MAX x DIM_MAX) over a valid/ready handshake.
//  - Transposes it one row per clock into an output register.
//  - Presents the result over a valid/ready handshake.
//  - Sits between the matrix load path and the arithmetic units that consume transposed operands.

---
 rtl/matrix_pkg.sv | 34 +++
 rtl/matrix_row_scatter.sv | 46 ++++
 rtl/transposicao_matriz_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the sequential matrix transpose engine.
// Used by transposicao_matriz_seq and matrix_row_scatter.
package matrix_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Dimensions and row indices; wide enough for any DIM_MAX up to 255.
  typedef logic [7:0] dim_t;

  typedef struct packed {
    dim_t n;
    logic err;
  } size_dec_t;

  // Code c selects an (c+2)x(c+2) matrix; oversize codes clamp to dim_max and flag err.
  function automatic size_dec_t size_decode(input int unsigned code, input int unsigned dim_max);
    size_dec_t   d;
    int unsigned n;
    n     = code + 2;
    d.err = (n > dim_max);
    if (d.err) n = dim_max;
    d.n = dim_t'(n);
    return d;
  endfunction

  function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned dim_max,
                                           input int unsigned elem_w);
    return (r * dim_max + c) * elem_w;
  endfunction

endpackage

// File: rtl/matrix_row_scatter.sv
// Combinational scatter of one source row into result-register positions.
// Anti-diagonal mapping and the i_mode port exist only when MATRIX_ANTIDIAG_EN is defined.
module matrix_row_scatter
  import matrix_pkg::*;
#(
  parameter int unsigned DIM_MAX = 5,
  parameter int unsigned ELEM_W  = 8
) (
  input  logic [DIM_MAX*ELEM_W-1:0]         i_row_data,
  input  dim_t                              i_row_idx,
  input  dim_t                              i_n,
`ifdef MATRIX_ANTIDIAG_EN
  input  logic                              i_mode,
`endif
  output logic [DIM_MAX*DIM_MAX-1:0]        o_we,
  output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0] o_data
);

  always_comb begin
    int unsigned n;
    int unsigned r;
    int unsigned dr;
    int unsigned dc;
    o_we   = '0;
    o_data = '0;
    n      = 32'(i_n);
    r      = 32'(i_row_idx);
    dr     = 0;
    dc     = 0;
    for (int unsigned c = 0; c < DIM_MAX; c++) begin
      if ((c < n) && (r < n)) begin
        dr = c;
        dc = r;
`ifdef MATRIX_ANTIDIAG_EN
        if (i_mode) begin
          dr = n - 1 - c;
          dc = n - 1 - r;
        end
`endif
        o_we[dr*DIM_MAX+dc] = 1'b1;
        o_data[elem_idx(dr, dc, DIM_MAX, ELEM_W) +: ELEM_W] = i_row_data[c*ELEM_W +: ELEM_W];
      end
    end
  end

endmodule

// File: rtl/transposicao_matriz_seq.sv
// Sequential matrix transpose engine: one source row per clock, result over valid/ready.
// Optional anti-diagonal transpose (mode port) when MATRIX_ANTIDIAG_EN is defined.
module transposicao_matriz_seq
  import matrix_pkg::*;
#(
  parameter int unsigned DIM_MAX  = 5,
  parameter int unsigned ELEM_W   = 8,
  localparam int unsigned SIZE_W  = (DIM_MAX > 2) ? $clog2(DIM_MAX - 1) : 1,
  localparam int unsigned MAT_W   = DIM_MAX * DIM_MAX * ELEM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MAT_W-1:0]  matrix_A,
  input  logic [SIZE_W-1:0] matrix_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MAT_W-1:0]  m_transposta_A,
  output logic              size_err
`ifdef MATRIX_ANTIDIAG_EN
  ,
  input  logic              mode
`endif
);

  logic [1:0]                 r_state;
  logic [MAT_W-1:0]           r_src;
  logic [MAT_W-1:0]           r_result;
  logic [MAT_W-1:0]           r_pipe_data;
  logic [DIM_MAX*DIM_MAX-1:0] r_pipe_we;
  logic                       r_pipe_vld;
  logic                       r_pipe_last;
  dim_t                       r_row;
  dim_t                       r_n;
  logic                       r_size_err;
`ifdef MATRIX_ANTIDIAG_EN
  logic                       r_mode;
`endif

  size_dec_t                  w_dec;
  logic [DIM_MAX*ELEM_W-1:0]  w_src_row;
  logic [DIM_MAX*DIM_MAX-1:0] w_we;
  logic [MAT_W-1:0]           w_data;
  logic [MAT_W-1:0]           w_result_next;

  assign w_dec = size_decode(32'(matrix_size), DIM_MAX);

  always_comb begin
    w_src_row = '0;
    if (r_row < dim_t'(DIM_MAX)) begin
      w_src_row = r_src[32'(r_row)*DIM_MAX*ELEM_W +: DIM_MAX*ELEM_W];
    end
  end

  matrix_row_scatter #(
    .DIM_MAX (DIM_MAX),
    .ELEM_W  (ELEM_W)
  ) u_scatter (
    .i_row_data (w_src_row),
    .i_row_idx  (r_row),
    .i_n        (r_n),
`ifdef MATRIX_ANTIDIAG_EN
    .i_mode     (r_mode),
`endif
    .o_we       (w_we),
    .o_data     (w_data)
  );

  for (genvar e = 0; e < DIM_MAX * DIM_MAX; e++) begin : g_merge
    assign w_result_next[e*ELEM_W +: ELEM_W] = r_pipe_we[e] ? r_pipe_data[e*ELEM_W +: ELEM_W]
                                                            : r_result[e*ELEM_W +: ELEM_W];
  end

  // Scatter output is registered once; the last row lands in r_result on the edge that
  // enters DONE, giving the n RUN cycles plus one capture cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_src       <= '0;
      r_result    <= '0;
      r_pipe_data <= '0;
      r_pipe_we   <= '0;
      r_pipe_vld  <= 1'b0;
      r_pipe_last <= 1'b0;
      r_row       <= '0;
      r_n         <= '0;
      r_size_err  <= 1'b0;
`ifdef MATRIX_ANTIDIAG_EN
      r_mode      <= 1'b0;
`endif
    end else begin
      r_size_err  <= 1'b0;
      r_pipe_vld  <= 1'b0;
      r_pipe_last <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_src      <= matrix_A;
            r_n        <= w_dec.n;
            r_size_err <= w_dec.err;
            r_result   <= '0;
            r_row      <= '0;
`ifdef MATRIX_ANTIDIAG_EN
            r_mode     <= mode;
`endif
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_row < r_n) begin
            r_pipe_we   <= w_we;
            r_pipe_data <= w_data;
            r_pipe_vld  <= 1'b1;
            r_pipe_last <= (r_row == r_n - 1'b1);
            r_row       <= r_row + 1'b1;
          end
          if (r_pipe_vld) r_result <= w_result_next;
          if (r_pipe_vld && r_pipe_last) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready       = (r_state == ST_IDLE);
  assign out_valid      = (r_state == ST_DONE);
  assign m_transposta_A = r_result;
  assign size_err       = r_size_err;

endmodule
